// File: rtl/instruction_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode_stage
// Purpose  : ID stage of a 5-stage MIPS pipeline. Decodes the IF/ID
//            instruction, reads the 32x32 register file (with WB bypass),
//            detects load-use and branch-operand hazards, resolves
//            branches/jumps in ID and drives the ID/EX pipeline register.
// Ports    : i_clock/i_reset            clock, asynchronous active-high reset
//            i_if_pc/i_if_instr         IF/ID register contents
//            i_stallEX                  hold ID/EX, suppress redirect
//            i_mem_reg_write/dst/result EX/MEM producer (branch operands)
//            i_wb_we/addr/data          register-file write port
//            o_stallID, o_jumpEnabled, o_pcJumpInput   to fetch (combinational)
//            o_idex_*                   ID/EX register (registered)
// Config   : `define ID_BRANCH_FWD_EN -> beq/bne/jr/jalr take an EX/MEM
//            match from i_mem_result instead of stalling.
// Revision : 1.0  initial release
// ============================================================================
module instruction_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RF_DEPTH = 32
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_if_instr,
  input  logic        i_stallEX,
  input  logic        i_mem_reg_write,
  input  logic [4:0]  i_mem_dst,
  input  logic [31:0] i_mem_result,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_stallID,
  output logic        o_jumpEnabled,
  output logic [31:0] o_pcJumpInput,
  output logic        o_idex_valid,
  output logic [31:0] o_idex_pc,
  output logic [31:0] o_idex_rs_val,
  output logic [31:0] o_idex_rt_val,
  output logic [31:0] o_idex_imm32,
  output logic [4:0]  o_idex_dst,
  output logic [3:0]  o_idex_alu_op,
  output logic        o_idex_alu_src,
  output logic        o_idex_mem_read,
  output logic        o_idex_mem_write,
  output logic        o_idex_reg_write
);

  // ALU operation codes; PASSB forwards operand B (lui, link address)
  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_and  = 4'd2;
  localparam logic [3:0] c_alu_or   = 4'd3;
  localparam logic [3:0] c_alu_xor  = 4'd4;
  localparam logic [3:0] c_alu_nor  = 4'd5;
  localparam logic [3:0] c_alu_slt  = 4'd6;
  localparam logic [3:0] c_alu_sltu = 4'd7;
  localparam logic [3:0] c_alu_sll  = 4'd8;
  localparam logic [3:0] c_alu_srl  = 4'd9;
  localparam logic [3:0] c_alu_sra  = 4'd10;
  localparam logic [3:0] c_alu_pass = 4'd11;

  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_sext, w_zext, w_pc4, w_pc8;

  assign w_opcode = i_if_instr[31:26];
  assign w_rs     = i_if_instr[25:21];
  assign w_rt     = i_if_instr[20:16];
  assign w_rd     = i_if_instr[15:11];
  assign w_funct  = i_if_instr[5:0];
  assign w_sext   = {{16{i_if_instr[15]}}, i_if_instr[15:0]};
  assign w_zext   = {16'd0, i_if_instr[15:0]};
  assign w_pc4    = i_if_pc + 32'd4;
  assign w_pc8    = i_if_pc + 32'd8;

  // ---------------- register file with same-cycle WB bypass ----------------
  logic [31:0] r_rf [RF_DEPTH];
  logic [31:0] w_rs_val, w_rt_val;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= 32'd0;
    end else if (i_wb_we && i_wb_addr != 5'd0) begin
      r_rf[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    w_rs_val = 32'd0;
    w_rt_val = 32'd0;
    if (w_rs != 5'd0) w_rs_val = (i_wb_we && i_wb_addr == w_rs) ? i_wb_data : r_rf[w_rs];
    if (w_rt != 5'd0) w_rt_val = (i_wb_we && i_wb_addr == w_rt) ? i_wb_data : r_rf[w_rt];
  end

  // ---------------- decode ----------------
  // Shifts keep the sign-extended immediate; EX takes shamt from imm32[10:6].
  logic       w_dec_valid, w_use_rs, w_use_rt, w_rw, w_mr, w_mw, w_src;
  logic       w_is_beq, w_is_bne, w_is_jimm, w_is_jreg;
  logic [4:0] w_dst;
  logic [3:0] w_alu_op;
  logic [31:0] w_imm32;

  always_comb begin
    w_dec_valid = 1'b0; w_use_rs = 1'b0; w_use_rt = 1'b0; w_rw = 1'b0;
    w_mr = 1'b0; w_mw = 1'b0; w_src = 1'b0; w_dst = 5'd0;
    w_is_beq = 1'b0; w_is_bne = 1'b0; w_is_jimm = 1'b0; w_is_jreg = 1'b0;
    w_alu_op = c_alu_add; w_imm32 = w_sext;
    case (w_opcode)
      6'h00: begin
        case (w_funct)
          6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
            w_dec_valid = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_rw = 1'b1; w_dst = w_rd;
            case (w_funct)
              6'h23:   w_alu_op = c_alu_sub;
              6'h24:   w_alu_op = c_alu_and;
              6'h25:   w_alu_op = c_alu_or;
              6'h26:   w_alu_op = c_alu_xor;
              6'h27:   w_alu_op = c_alu_nor;
              6'h2a:   w_alu_op = c_alu_slt;
              6'h2b:   w_alu_op = c_alu_sltu;
              default: w_alu_op = c_alu_add;
            endcase
          end
          6'h00, 6'h02, 6'h03: begin
            w_dec_valid = 1'b1; w_use_rt = 1'b1; w_rw = 1'b1; w_dst = w_rd;
            w_alu_op = (w_funct == 6'h00) ? c_alu_sll : (w_funct == 6'h02) ? c_alu_srl : c_alu_sra;
          end
          6'h08: begin w_dec_valid = 1'b1; w_use_rs = 1'b1; w_is_jreg = 1'b1; end
          6'h09: begin
            w_dec_valid = 1'b1; w_use_rs = 1'b1; w_is_jreg = 1'b1; w_rw = 1'b1; w_dst = w_rd;
            w_src = 1'b1; w_alu_op = c_alu_pass; w_imm32 = w_pc8;
          end
          default: ;
        endcase
      end
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
        w_dec_valid = 1'b1; w_use_rs = 1'b1; w_rw = 1'b1; w_dst = w_rt; w_src = 1'b1;
        case (w_opcode)
          6'h0a:   w_alu_op = c_alu_slt;
          6'h0b:   w_alu_op = c_alu_sltu;
          6'h0c:   begin w_alu_op = c_alu_and; w_imm32 = w_zext; end
          6'h0d:   begin w_alu_op = c_alu_or;  w_imm32 = w_zext; end
          6'h0e:   begin w_alu_op = c_alu_xor; w_imm32 = w_zext; end
          default: w_alu_op = c_alu_add;
        endcase
      end
      6'h0f: begin
        w_dec_valid = 1'b1; w_rw = 1'b1; w_dst = w_rt; w_src = 1'b1;
        w_alu_op = c_alu_pass; w_imm32 = {i_if_instr[15:0], 16'd0};
      end
      6'h23: begin w_dec_valid = 1'b1; w_use_rs = 1'b1; w_rw = 1'b1; w_dst = w_rt; w_src = 1'b1; w_mr = 1'b1; end
      6'h2b: begin w_dec_valid = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_src = 1'b1; w_mw = 1'b1; end
      6'h04: begin w_dec_valid = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_is_beq = 1'b1; end
      6'h05: begin w_dec_valid = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; w_is_bne = 1'b1; end
      6'h02: begin w_dec_valid = 1'b1; w_is_jimm = 1'b1; end
      6'h03: begin
        w_dec_valid = 1'b1; w_is_jimm = 1'b1; w_rw = 1'b1; w_dst = 5'd31;
        w_src = 1'b1; w_alu_op = c_alu_pass; w_imm32 = w_pc8;
      end
      default: ;
    endcase
  end

  // ---------------- hazards and branch resolution ----------------
  logic w_ex_hit, w_mem_hit_rs, w_mem_hit_rt, w_br_reg, w_load_use, w_br_ex_dep, w_br_mem_stall, w_taken;
  logic [31:0] w_br_a, w_br_b, w_target;

  assign w_ex_hit     = (o_idex_dst != 5'd0) &&
                        ((w_use_rs && w_rs == o_idex_dst) || (w_use_rt && w_rt == o_idex_dst));
  assign w_mem_hit_rs = i_mem_reg_write && i_mem_dst != 5'd0 && w_use_rs && w_rs == i_mem_dst;
  assign w_mem_hit_rt = i_mem_reg_write && i_mem_dst != 5'd0 && w_use_rt && w_rt == i_mem_dst;
  assign w_br_reg     = w_is_beq || w_is_bne || w_is_jreg;
  assign w_load_use   = o_idex_mem_read && w_ex_hit;
  // EX results are never available in ID, so a register branch always waits on them
  assign w_br_ex_dep  = w_br_reg && o_idex_reg_write && w_ex_hit;

`ifdef ID_BRANCH_FWD_EN
  assign w_br_mem_stall = 1'b0;
  assign w_br_a = w_mem_hit_rs ? i_mem_result : w_rs_val;
  assign w_br_b = w_mem_hit_rt ? i_mem_result : w_rt_val;
`else
  logic w_unused_mem_result;
  assign w_unused_mem_result = ^i_mem_result;
  assign w_br_mem_stall = w_br_reg && (w_mem_hit_rs || w_mem_hit_rt);
  assign w_br_a = w_rs_val;
  assign w_br_b = w_rt_val;
`endif

  assign o_stallID = w_load_use || w_br_ex_dep || w_br_mem_stall;

  always_comb begin
    w_taken  = 1'b0;
    w_target = 32'd0;
    if (w_is_beq || w_is_bne) begin
      w_taken  = w_is_beq ? (w_br_a == w_br_b) : (w_br_a != w_br_b);
      w_target = w_pc4 + {w_sext[29:0], 2'b00};
    end else if (w_is_jimm) begin
      w_taken  = 1'b1;
      w_target = {w_pc4[31:28], i_if_instr[25:0], 2'b00};
    end else if (w_is_jreg) begin
      w_taken  = 1'b1;
      w_target = w_br_a;
    end
  end

  // A stalled branch retries next cycle, so gating here makes it redirect once
  assign o_jumpEnabled = w_taken && !o_stallID && !i_stallEX;
  assign o_pcJumpInput = w_target;

  // ---------------- ID/EX register ----------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_idex_valid <= 1'b0; o_idex_pc <= RESET_PC; o_idex_rs_val <= 32'd0; o_idex_rt_val <= 32'd0;
      o_idex_imm32 <= 32'd0; o_idex_dst <= 5'd0; o_idex_alu_op <= 4'd0; o_idex_alu_src <= 1'b0;
      o_idex_mem_read <= 1'b0; o_idex_mem_write <= 1'b0; o_idex_reg_write <= 1'b0;
    end else if (i_stallEX) begin
      // hold
    end else if (o_stallID || !w_dec_valid) begin
      o_idex_valid <= 1'b0; o_idex_pc <= 32'd0; o_idex_rs_val <= 32'd0; o_idex_rt_val <= 32'd0;
      o_idex_imm32 <= 32'd0; o_idex_dst <= 5'd0; o_idex_alu_op <= 4'd0; o_idex_alu_src <= 1'b0;
      o_idex_mem_read <= 1'b0; o_idex_mem_write <= 1'b0; o_idex_reg_write <= 1'b0;
    end else begin
      o_idex_valid     <= 1'b1;
      o_idex_pc        <= i_if_pc;
      o_idex_rs_val    <= w_use_rs ? w_rs_val : 32'd0;
      o_idex_rt_val    <= w_use_rt ? w_rt_val : 32'd0;
      o_idex_imm32     <= w_imm32;
      o_idex_dst       <= w_dst;
      o_idex_alu_op    <= w_alu_op;
      o_idex_alu_src   <= w_src;
      o_idex_mem_read  <= w_mr;
      o_idex_mem_write <= w_mw;
      o_idex_reg_write <= w_rw;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decode_stage
// Purpose  : directed stimulus for instruction_decode_stage with a mnemonic-
//            level reference model checked every cycle, plus literal checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_instruction_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4, A_NOR = 5,
                         A_SLT = 6, A_SLTU = 7, A_SLL = 8, A_SRL = 9, A_SRA = 10, A_PASS = 11;
`ifdef ID_BRANCH_FWD_EN
  localparam int EXP_BR_STALLS = 1;
`else
  localparam int EXP_BR_STALLS = 2;
`endif

  logic clk, rst, stallEX, mem_reg_write, wb_we;
  logic [31:0] if_pc, if_instr, mem_result, wb_data;
  logic [4:0] mem_dst, wb_addr;
  logic stallID, jumpEnabled, idex_valid, idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write;
  logic [31:0] pcJumpInput, idex_pc, idex_rs_val, idex_rt_val, idex_imm32;
  logic [4:0] idex_dst;
  logic [3:0] idex_alu_op;

  instruction_decode_stage #(.RESET_PC(RESET_PC), .RF_DEPTH(32)) dut (
    .i_clock(clk), .i_reset(rst), .i_if_pc(if_pc), .i_if_instr(if_instr), .i_stallEX(stallEX),
    .i_mem_reg_write(mem_reg_write), .i_mem_dst(mem_dst), .i_mem_result(mem_result),
    .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_stallID(stallID), .o_jumpEnabled(jumpEnabled), .o_pcJumpInput(pcJumpInput),
    .o_idex_valid(idex_valid), .o_idex_pc(idex_pc), .o_idex_rs_val(idex_rs_val),
    .o_idex_rt_val(idex_rt_val), .o_idex_imm32(idex_imm32), .o_idex_dst(idex_dst),
    .o_idex_alu_op(idex_alu_op), .o_idex_alu_src(idex_alu_src), .o_idex_mem_read(idex_mem_read),
    .o_idex_mem_write(idex_mem_write), .o_idex_reg_write(idex_reg_write));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_BAD, M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_SLL, M_SRL,
                    M_SRA, M_JR, M_JALR, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
                    M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL} mn_t;

  typedef struct packed {
    logic v; logic [31:0] pc, rs, rt, imm; logic [4:0] dst; logic [3:0] op;
    logic src, mr, mw, rw;
  } idex_t;

  idex_t m_ex;
  logic [31:0] m_rf [32];

  function automatic mn_t mnemonic(input logic [31:0] ins);
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h21: return M_ADDU;  6'h23: return M_SUBU; 6'h24: return M_AND;  6'h25: return M_OR;
        6'h26: return M_XOR;   6'h27: return M_NOR;  6'h2a: return M_SLT;  6'h2b: return M_SLTU;
        6'h00: return M_SLL;   6'h02: return M_SRL;  6'h03: return M_SRA;  6'h08: return M_JR;
        6'h09: return M_JALR;  default: return M_BAD;
      endcase
    end
    case (ins[31:26])
      6'h09: return M_ADDIU; 6'h0a: return M_SLTI; 6'h0b: return M_SLTIU; 6'h0c: return M_ANDI;
      6'h0d: return M_ORI;   6'h0e: return M_XORI; 6'h0f: return M_LUI;   6'h23: return M_LW;
      6'h2b: return M_SW;    6'h04: return M_BEQ;  6'h05: return M_BNE;   6'h02: return M_J;
      6'h03: return M_JAL;   default: return M_BAD;
    endcase
  endfunction

  function automatic logic [31:0] regval(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  task automatic model_eval(output idex_t nx, output logic st, output logic je, output logic [31:0] tg);
    mn_t m = mnemonic(if_instr);
    logic [4:0] rs = if_instr[25:21], rt = if_instr[20:16], rd = if_instr[15:11];
    logic [31:0] se = {{16{if_instr[15]}}, if_instr[15:0]};
    logic [31:0] pc4 = if_pc + 4;
    logic r3 = m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU};
    logic sh = m inside {M_SLL, M_SRL, M_SRA};
    logic ialu = m inside {M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI};
    logic urs = !(sh || m inside {M_BAD, M_LUI, M_J, M_JAL});
    logic urt = r3 || sh || m inside {M_SW, M_BEQ, M_BNE};
    logic brreg = m inside {M_BEQ, M_BNE, M_JR, M_JALR};
    logic dep_ex = m_ex.dst != 0 && ((urs && rs == m_ex.dst) || (urt && rt == m_ex.dst));
    logic mem_rs = mem_reg_write && mem_dst != 0 && urs && rs == mem_dst;
    logic mem_rt = mem_reg_write && mem_dst != 0 && urt && rt == mem_dst;
    logic taken = 0;
    logic [31:0] a = regval(rs), b = regval(rt);
    st = (m_ex.mr && dep_ex) || (brreg && m_ex.rw && dep_ex);
`ifdef ID_BRANCH_FWD_EN
    if (mem_rs) a = mem_result;
    if (mem_rt) b = mem_result;
`else
    if (brreg && (mem_rs || mem_rt)) st = 1;
`endif
    tg = 0;
    case (m)
      M_BEQ:        begin taken = (a == b); tg = pc4 + (se << 2); end
      M_BNE:        begin taken = (a != b); tg = pc4 + (se << 2); end
      M_J, M_JAL:   begin taken = 1; tg = {pc4[31:28], if_instr[25:0], 2'b00}; end
      M_JR, M_JALR: begin taken = 1; tg = a; end
      default: ;
    endcase
    je = taken && !st && !stallEX;
    nx = '0;
    if (!st && m != M_BAD) begin
      nx.v  = 1; nx.pc = if_pc;
      nx.rs = urs ? regval(rs) : 0;
      nx.rt = urt ? regval(rt) : 0;
      nx.rw = r3 || sh || ialu || m inside {M_LUI, M_LW, M_JAL, M_JALR};
      nx.dst = (r3 || sh || m == M_JALR) ? rd : (ialu || m inside {M_LUI, M_LW}) ? rt : (m == M_JAL) ? 5'd31 : 5'd0;
      nx.src = ialu || m inside {M_LUI, M_LW, M_SW, M_JAL, M_JALR};
      nx.mr = (m == M_LW); nx.mw = (m == M_SW);
      case (m)
        M_ANDI, M_ORI, M_XORI: nx.imm = {16'd0, if_instr[15:0]};
        M_LUI:                 nx.imm = {if_instr[15:0], 16'd0};
        M_JAL, M_JALR:         nx.imm = if_pc + 8;
        default:               nx.imm = se;
      endcase
      case (m)
        M_SUBU: nx.op = A_SUB;              M_AND, M_ANDI: nx.op = A_AND;
        M_OR, M_ORI: nx.op = A_OR;          M_XOR, M_XORI: nx.op = A_XOR;
        M_NOR: nx.op = A_NOR;               M_SLT, M_SLTI: nx.op = A_SLT;
        M_SLTU, M_SLTIU: nx.op = A_SLTU;    M_SLL: nx.op = A_SLL;
        M_SRL: nx.op = A_SRL;               M_SRA: nx.op = A_SRA;
        M_LUI, M_JAL, M_JALR: nx.op = A_PASS;
        default: nx.op = A_ADD;
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    idex_t nx; logic st, je; logic [31:0] tg;
    if (rst) begin
      m_ex = '0; m_ex.pc = RESET_PC;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      model_eval(nx, st, je, tg);
      if (!stallEX) m_ex = nx;
      if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    idex_t nx; logic st, je; logic [31:0] tg;
    if (!rst) begin
      model_eval(nx, st, je, tg);
      chk("m_stallID", {31'd0, stallID}, {31'd0, st});
      chk("m_jump", {31'd0, jumpEnabled}, {31'd0, je});
      if (je) chk("m_target", pcJumpInput, tg);
      chk("m_valid", {31'd0, idex_valid}, {31'd0, m_ex.v});
      chk("m_pc", idex_pc, m_ex.pc);
      chk("m_rs", idex_rs_val, m_ex.rs);
      chk("m_rt", idex_rt_val, m_ex.rt);
      chk("m_imm", idex_imm32, m_ex.imm);
      chk("m_dst", {27'd0, idex_dst}, {27'd0, m_ex.dst});
      chk("m_op", {28'd0, idex_alu_op}, {28'd0, m_ex.op});
      chk("m_ctl", {28'd0, idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write},
                   {28'd0, m_ex.src, m_ex.mr, m_ex.mw, m_ex.rw});
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] R(input logic [5:0] fn, input logic [4:0] rs, rt, rd, input logic [4:0] sa);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction
  function automatic logic [31:0] I(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic put(input logic [31:0] pc, input logic [31:0] ins);
    if_pc = pc; if_instr = ins;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    clk = 0; rst = 1; stallEX = 0; mem_reg_write = 0; mem_dst = 0; mem_result = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; put(0, 0);
    repeat (2) cyc();
    #1;
    chk("rst_valid", {31'd0, idex_valid}, 0);
    chk("rst_pc", idex_pc, RESET_PC);
    chk("rst_regw", {31'd0, idex_reg_write}, 0);
    rst = 0;

    // WB write bypassed into same-cycle read
    wb_we = 1; wb_addr = 1; wb_data = 7; put(32'h10, R(6'h21, 1, 1, 3, 0));
    cyc(); wb_we = 0;
    chk("add_valid", {31'd0, idex_valid}, 1);
    chk("add_rs", idex_rs_val, 7);
    chk("add_rt", idex_rt_val, 7);
    chk("add_dst", {27'd0, idex_dst}, 3);
    chk("add_op", {28'd0, idex_alu_op}, A_ADD);

    wb_we = 1; wb_addr = 5; wb_data = 32'h55; put(32'h14, I(6'h0d, 1, 5, 16'h8001));
    cyc(); wb_we = 0;
    chk("ori_imm", idex_imm32, 32'h0000_8001);
    chk("ori_op", {28'd0, idex_alu_op}, A_OR);
    put(32'h18, I(6'h0f, 0, 6, 16'h1234));
    cyc(); chk("lui_imm", idex_imm32, 32'h1234_0000);
    put(32'h1c, I(6'h09, 1, 7, 16'hfffc));
    cyc(); chk("addiu_imm", idex_imm32, 32'hffff_fffc);
    put(32'h20, R(6'h03, 0, 1, 8, 3));
    cyc(); chk("sra_rt", idex_rt_val, 7); chk("sra_imm", idex_imm32, 32'h0000_40c3);
    put(32'h24, 32'hfc00_0000);
    cyc(); chk("bad_bubble", {31'd0, idex_valid}, 0);

    // load-use
    put(32'h28, I(6'h23, 1, 2, 0));
    cyc(); put(32'h2c, R(6'h21, 2, 2, 4, 0));
    #1 chk("lu_stall", {31'd0, stallID}, 1);
    cyc(); chk("lu_bubble", {31'd0, idex_valid}, 0);
    #1 chk("lu_release", {31'd0, stallID}, 0);
    cyc(); chk("lu_issue", {27'd0, idex_dst}, 4);

    // branch taken, delay slot issues
    put(32'h40, I(6'h04, 0, 0, 16'd3));
    #1 chk("beq_jump", {31'd0, jumpEnabled}, 1); chk("beq_target", pcJumpInput, 32'h50);
    cyc(); put(32'h44, R(6'h21, 1, 1, 10, 0));
    #1 chk("beq_once", {31'd0, jumpEnabled}, 0);
    cyc(); chk("slot_pc", idex_pc, 32'h44); chk("slot_valid", {31'd0, idex_valid}, 1);

    // jal link
    put(32'h20, {6'h03, 26'h40});
    #1 chk("jal_target", pcJumpInput, 32'h100); chk("jal_jump", {31'd0, jumpEnabled}, 1);
    cyc(); chk("jal_dst", {27'd0, idex_dst}, 31); chk("jal_imm", idex_imm32, 32'h28);
    put(32'h24, 0);
    cyc();

    // branch operand produced by the preceding instruction ($1 <- 0)
    put(32'h60, R(6'h21, 0, 0, 1, 0));
    cyc(); put(32'h64, I(6'h04, 1, 0, 16'd2));
    stalls = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (!stallID) break;
      stalls++;
      cyc();
      if (stalls == 1) begin mem_reg_write = 1; mem_dst = 1; mem_result = 0; end
      else if (stalls == 2) begin mem_reg_write = 0; wb_we = 1; wb_addr = 1; wb_data = 0; end
    end
    chk("dep_stalls", stalls, EXP_BR_STALLS);
    chk("dep_jump", {31'd0, jumpEnabled}, 1);
    chk("dep_target", pcJumpInput, 32'h70);
    cyc(); mem_reg_write = 0; wb_we = 0;

    // downstream hold
    put(32'h80, I(6'h04, 0, 0, 16'd1)); stallEX = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_nojump", {31'd0, jumpEnabled}, 0);
      cyc(); chk("hold_pc", idex_pc, 32'h64);
    end
    stallEX = 0;
    #1 chk("hold_jump", {31'd0, jumpEnabled}, 1); chk("hold_target", pcJumpInput, 32'h88);
    cyc(); chk("hold_issue", idex_pc, 32'h80);

    // asynchronous reset mid-cycle
    put(32'h90, R(6'h21, 1, 1, 11, 0));
    cyc(); #2 rst = 1;
    #1 chk("arst_valid", {31'd0, idex_valid}, 0); chk("arst_pc", idex_pc, RESET_PC);
    chk("arst_dst", {27'd0, idex_dst}, 0); chk("arst_imm", idex_imm32, 0);
    cyc(); rst = 0; put(32'h94, R(6'h21, 5, 0, 9, 0));
    cyc(); chk("arst_r5", idex_rs_val, 0); chk("arst_issue", {31'd0, idex_valid}, 1);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
